// File: rtl/ahb_xfer_monitor.sv
// Passive AHB-Lite transfer monitor: tracks the address/data pipeline and
// queues each completed transfer (address, data, direction, error) in a small FIFO.
module ahb_xfer_monitor #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [ADDR_W-1:0]          haddr,
    input  logic [1:0]                 htrans,
    input  logic                       hwrite,
    input  logic                       hready,
    input  logic                       hresp,
    input  logic [DATA_W-1:0]          hwdata,
    input  logic [DATA_W-1:0]          hrdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_write,
    output logic                       out_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
    logic              pend_write_q, pend_write_d;
    logic              err_flag_q,   err_flag_d;

    logic [PW-1:0]     wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]     count_q,   count_d;
    logic [7:0]        drop_q,    drop_d;

    logic [ADDR_W-1:0] mem_addr_q  [DEPTH];
    logic [DATA_W-1:0] mem_data_q  [DEPTH];
    logic              mem_write_q [DEPTH];
    logic              mem_err_q   [DEPTH];

    logic              addr_phase_s;
    logic              complete_s;
    logic              full_s;
    logic              pop_s;
    logic              wr_en_s;
    logic              drop_s;
    logic              ent_err_s;
    logic [DATA_W-1:0] ent_data_s;
    logic              unused_s;

    // htrans[0] only distinguishes NONSEQ from SEQ, which the monitor treats alike
    assign unused_s     = htrans[0];
    assign addr_phase_s = hready & htrans[1];
    assign complete_s   = pend_valid_q & hready;
    assign full_s       = (count_q == FULL_C);
    assign pop_s        = out_valid & out_ready;
    // A completion while full is kept only if the head leaves on the same edge
    assign wr_en_s      = complete_s & (~full_s | pop_s);
    assign drop_s       = complete_s & full_s & ~pop_s;

    // Pending-transfer and error-flag next state
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_write_d = pend_write_q;
        err_flag_d   = err_flag_q;
        if (addr_phase_s) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = haddr;
            pend_write_d = hwrite;
        end else if (complete_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
        if (complete_s) begin
            err_flag_d = 1'b0;
        end else if (pend_valid_q && hresp) begin
            err_flag_d = 1'b1;
        end else begin
            err_flag_d = err_flag_q;
        end
    end

    // Completed-entry fields; erroneous transfers carry no data
    always_comb begin
        ent_err_s = hresp | err_flag_q;
        if (ent_err_s) begin
            ent_data_s = {DATA_W{1'b0}};
        end else if (pend_write_q) begin
            ent_data_s = hwdata;
        end else begin
            ent_data_s = hrdata;
        end
    end

    // FIFO pointer, occupancy and drop-counter next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop_s && (drop_q != 8'd255)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= {ADDR_W{1'b0}};
            pend_write_q <= 1'b0;
            err_flag_q   <= 1'b0;
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            count_q      <= {CW{1'b0}};
            drop_q       <= 8'd0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_write_q <= pend_write_d;
            err_flag_q   <= err_flag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
        end
    end

    // FIFO storage; contents are only observable through the valid-gated outputs
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_addr_q[wr_ptr_q]  <= pend_addr_q;
            mem_data_q[wr_ptr_q]  <= ent_data_s;
            mem_write_q[wr_ptr_q] <= pend_write_q;
            mem_err_q[wr_ptr_q]   <= ent_err_s;
        end else begin
            mem_addr_q[wr_ptr_q]  <= mem_addr_q[wr_ptr_q];
        end
    end

    assign out_valid = (count_q != {CW{1'b0}});
    assign out_addr  = out_valid ? mem_addr_q[rd_ptr_q]  : {ADDR_W{1'b0}};
    assign out_data  = out_valid ? mem_data_q[rd_ptr_q]  : {DATA_W{1'b0}};
    assign out_write = out_valid ? mem_write_q[rd_ptr_q] : 1'b0;
    assign out_err   = out_valid ? mem_err_q[rd_ptr_q]   : 1'b0;
    assign count     = count_q;
    assign drop_cnt  = drop_q;

endmodule

// File: doc/ahb_xfer_monitor.md
AHB_XFER_MONITOR -- requirements
Module: ahb_xfer_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter DEPTH, default 4, capture FIFO entries; power of two, >=2.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port haddr  in  ADDR_W  AHB address.
REQ-007 SHALL have port htrans  in  2  AHB transfer type.
REQ-008 SHALL have port hwrite  in  1  AHB direction, 1=write.
REQ-009 SHALL have port hready  in  1  AHB transfer-done / bus ready.
REQ-010 SHALL have port hresp  in  1  AHB error response.
REQ-011 SHALL have port hwdata  in  DATA_W  write data.
REQ-012 SHALL have port hrdata  in  DATA_W  read data.
REQ-013 SHALL have port out_valid  out  1  FIFO head valid.
REQ-014 SHALL have port out_ready  in  1  consumer accepts head.
REQ-015 SHALL have port out_addr / out_data / out_write / out_err  out  ADDR_W / DATA_W / 1 / 1  head entry fields.
REQ-016 SHALL have port count  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port drop_cnt  out  8  saturating count of completions lost to a full FIFO.

Function
REQ-018 SHALL accept an address phase when hready=1 and htrans[1]=1 (NONSEQ/SEQ); IDLE/BUSY and hready=0 cycles are ignored.
REQ-019 SHALL hold one pending transfer (valid, addr, write) loaded by an accepted address phase.
REQ-020 SHALL complete the pending transfer on the first cycle with pending valid and hready=1.
REQ-021 SHALL clear pending on completion unless a new address phase is accepted in the same cycle; then pending loads the new phase (back-to-back pipelining, no bubble).
REQ-022 SHALL capture data at completion as hwdata when pending write=1, else hrdata.
REQ-023 SHALL latch an error flag when hresp=1 while pending valid; the flag clears on completion.
REQ-024 SHALL mark a completed entry err=1 if hresp=1 at completion or the flag is set, and force its data field to 0.
REQ-025 SHALL push each completion into the FIFO; the entry is visible on out_* one cycle after the completion edge, with no same-cycle bypass.
REQ-026 SHALL drive out_valid=(count!=0) and present the head entry on out_*.
REQ-027 SHALL pop the head on a rising edge where out_valid=1 and out_ready=1.
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL, when full, drop a completion and increment drop_cnt, saturating at 255; count is unchanged.
REQ-030 SHALL, on simultaneous pop and push while full, accept the push; count stays DEPTH and drop_cnt is unchanged.
REQ-031 SHALL, on simultaneous pop and push at any other occupancy, leave count unchanged.
REQ-032 SHALL not disturb FIFO contents or out_* while out_valid=1 and out_ready=0.

Reset
REQ-033 SHALL, on rstn=0, clear pending, the error flag, pointers, count and drop_cnt; out_valid=0, out_addr=0, out_data=0, out_write=0, out_err=0.
REQ-034 SHALL discard any in-flight transfer when reset asserts mid-transfer; the first completion after reset produces no entry unless its address phase follows reset release.

Verification
REQ-035 Single read: NONSEQ haddr=0x100, hwrite=0; next cycle hready=1, hrdata=0xDEADBEEF -> one cycle later out_valid=1, addr 0x100, data 0xDEADBEEF, write=0, err=0, count=1.
REQ-036 Back-to-back: writes to 0x0, 0x4, 0x8 with hwdata 1, 2, 3 and hready held 1 -> three entries in order, count=3, no bubbles.
REQ-037 Wait states: read 0x20 with hready=0 for 3 cycles, then hready=1 with hrdata=0x55 -> exactly one entry, data 0x55.
REQ-038 Error: write 0x40; hresp=1/hready=0, then hresp=1/hready=1 -> entry err=1, data=0.
REQ-039 Overflow: DEPTH=4, out_ready=0, 6 completions -> count=4, drop_cnt=2; then out_ready=1 -> first 4 entries drain in order.
REQ-040 Reset mid-op: rstn low during a pending read's wait state -> all outputs 0; completion after release yields no entry.
